// File: rtl/shift_transmitter.sv
// Parallel-to-serial shifter for the JTAG data register path: captures a word on load,
// emits len bits (MSB- or LSB-first) one per enable, pulses done with the last bit.
//   state   | meaning
//   S_IDLE  | waiting for load; out holds the last emitted bit
//   S_SHIFT | word latched; one bit leaves per enabled cycle
module shift_transmitter #(
  parameter int WIDTH     = 32,
  parameter int LSB_FIRST = 0,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic [CW-1:0]    len,
  input  logic             enable,
  output logic             out,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    bits_left
);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  localparam logic [CW-1:0] W_CW = CW'(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt, w_load_word;
  logic [CW-1:0]    r_bits_left, w_bits_nxt, w_len_eff, w_shamt;
  logic             r_out, w_out_nxt;
  logic             r_done, w_done_nxt;

  assign w_len_eff = ((len == '0) || (len > W_CW)) ? W_CW : len;
  assign w_shamt   = W_CW - w_len_eff;
  // MSB-first left-aligns a short word so the shifter always drains from the top bit.
  assign w_load_word = (LSB_FIRST != 0) ? in : (in << w_shamt);

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bits_nxt  = r_bits_left;
    w_out_nxt   = r_out;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_shift_nxt = w_load_word;
          w_bits_nxt  = w_len_eff;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (enable) begin
          w_out_nxt   = (LSB_FIRST != 0) ? r_shift[0] : r_shift[WIDTH-1];
          w_shift_nxt = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
          w_bits_nxt  = r_bits_left - 1'b1;
          if (r_bits_left == CW'(1)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bits_left <= '0;
      r_out       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bits_left <= w_bits_nxt;
      r_out       <= w_out_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign out       = r_out;
  assign done      = r_done;
  assign bits_left = r_bits_left;
  assign ready     = (r_state == S_IDLE);
  assign busy      = (r_state == S_SHIFT);

endmodule

// File: tb/tb_shift_transmitter.sv
// Bench for shift_transmitter: MSB-first and LSB-first instances share stimulus; a
// behavioural model queues expected outputs per cycle, plus a table of whole-word checks.
module tb_shift_transmitter;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset, load, enable;
  logic [WIDTH-1:0] in_w;
  logic [CW-1:0]    len_w;
  logic             out0, ready0, busy0, done0;
  logic             out1, ready1, busy1, done1;
  logic [CW-1:0]    left0, left1;

  always #5 clk = ~clk;

  shift_transmitter #(.WIDTH(WIDTH), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .load(load), .in(in_w), .len(len_w), .enable(enable),
    .out(out0), .ready(ready0), .busy(busy0), .done(done0), .bits_left(left0));

  shift_transmitter #(.WIDTH(WIDTH), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .reset(reset), .load(load), .in(in_w), .len(len_w), .enable(enable),
    .out(out1), .ready(ready1), .busy(busy1), .done(done1), .bits_left(left1));

  typedef struct packed {
    logic          out;
    logic          done;
    logic          rdy;
    logic          busy;
    logic [CW-1:0] left;
    logic          emit;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    logic [CW-1:0] len;
    int          nbits;
    logic [31:0] exp_msb;
    logic [31:0] exp_lsb;
  } vec_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        m_busy = 1'b0;
  logic        m_out0 = 1'b0, m_out1 = 1'b0, m_done = 1'b0;
  logic [31:0] m_word = '0;
  int          m_leff = 0, m_pos = 0, m_left = 0;

  // collected serial words and done counts
  logic [31:0] col0, col1;
  int          ndone0, ndone1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic step(input logic rst, input logic ld, input logic en,
                      input logic [31:0] w, input logic [CW-1:0] l);
    logic emit;
    @(negedge clk);
    reset = rst; load = ld; enable = en; in_w = w; len_w = l;
    emit = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_out0 = 1'b0; m_out1 = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (ld) begin
          m_word = w;
          m_leff = ((l == 0) || (int'(l) > WIDTH)) ? WIDTH : int'(l);
          m_pos  = 0;
          m_left = m_leff;
          m_busy = 1'b1;
        end
      end else if (en) begin
        m_out0 = m_word[m_leff - 1 - m_pos];
        m_out1 = m_word[m_pos];
        m_pos++;
        m_left--;
        emit = 1'b1;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
    sb0.push_back('{out: m_out0, done: m_done, rdy: !m_busy, busy: m_busy,
                    left: CW'(m_left), emit: emit});
    sb1.push_back('{out: m_out1, done: m_done, rdy: !m_busy, busy: m_busy,
                    left: CW'(m_left), emit: emit});
    @(posedge clk);
    #2;
  endtask

  // scoreboard: pop one expectation per DUT after every edge
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb0.size() != 0) begin
      e = sb0.pop_front();
      total++;
      if ({out0, done0, ready0, busy0, left0} !== {e.out, e.done, e.rdy, e.busy, e.left}) begin
        bad++;
        $display("FAIL msb cycle t=%0t: got out=%b done=%b rdy=%b busy=%b left=%0d want out=%b done=%b rdy=%b busy=%b left=%0d",
                 $time, out0, done0, ready0, busy0, left0, e.out, e.done, e.rdy, e.busy, e.left);
      end
      if (e.emit) col0 = {col0[30:0], out0};
      if (done0) ndone0++;
    end
    if (sb1.size() != 0) begin
      e = sb1.pop_front();
      total++;
      if ({out1, done1, ready1, busy1, left1} !== {e.out, e.done, e.rdy, e.busy, e.left}) begin
        bad++;
        $display("FAIL lsb cycle t=%0t: got out=%b done=%b rdy=%b busy=%b left=%0d want out=%b done=%b rdy=%b busy=%b left=%0d",
                 $time, out1, done1, ready1, busy1, left1, e.out, e.done, e.rdy, e.busy, e.left);
      end
      if (e.emit) col1 = {col1[30:0], out1};
      if (done1) ndone1++;
    end
  end

  task automatic clear_col();
    col0 = '0; col1 = '0; ndone0 = 0; ndone1 = 0;
  endtask

  initial begin
    vec_t vecs[7];
    int   n;
    logic [6:0] gap;

    vecs[0] = '{word: 32'hA5A5_0F0F, len: 6'd0,  nbits: 32, exp_msb: 32'hA5A5_0F0F, exp_lsb: 32'hF0F0_A5A5};
    vecs[1] = '{word: 32'h0000_00B2, len: 6'd5,  nbits: 5,  exp_msb: 32'h12,         exp_lsb: 32'h09};
    vecs[2] = '{word: 32'hFFFF_FFFF, len: 6'd40, nbits: 32, exp_msb: 32'hFFFF_FFFF, exp_lsb: 32'hFFFF_FFFF};
    vecs[3] = '{word: 32'h0000_0001, len: 6'd1,  nbits: 1,  exp_msb: 32'h1,          exp_lsb: 32'h1};
    vecs[4] = '{word: 32'h0000_000C, len: 6'd4,  nbits: 4,  exp_msb: 32'hC,          exp_lsb: 32'h3};
    vecs[5] = '{word: 32'h1234_5678, len: 6'd33, nbits: 32, exp_msb: 32'h1234_5678, exp_lsb: 32'h1E6A_2C48};
    vecs[6] = '{word: 32'h0000_DEAD, len: 6'd16, nbits: 16, exp_msb: 32'hDEAD,       exp_lsb: 32'hB57B};

    reset = 1'b1; load = 1'b0; enable = 1'b0; in_w = '0; len_w = '0;
    clear_col();
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 32'hFFFF_FFFF, 0);
    chk("reset ready", {31'b0, ready0}, 32'h1);
    chk("reset left",  {26'b0, left0}, 32'h0);

    // table: load immediately after reset, then continuous enable
    for (int i = 0; i < 7; i++) begin
      clear_col();
      step(0, 1, 0, vecs[i].word, vecs[i].len);
      n = 0;
      while (m_busy && n < 40) begin
        step(0, 0, 1, 0, 0);
        n++;
      end
      chk($sformatf("vec%0d cycles", i), n, vecs[i].nbits);
      chk($sformatf("vec%0d msb word", i), col0, vecs[i].exp_msb);
      chk($sformatf("vec%0d lsb word", i), col1, vecs[i].exp_lsb);
      chk($sformatf("vec%0d done msb", i), ndone0, 1);
      chk($sformatf("vec%0d done lsb", i), ndone1, 1);
    end

    // idle enables are inert
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // gapped enable
    clear_col();
    step(0, 1, 0, 32'hC, 4);
    gap = 7'b1001011;
    for (int i = 6; i >= 0; i--) step(0, 0, gap[i], 0, 0);
    chk("gap msb word", col0, 32'hC);
    chk("gap done", ndone0, 1);

    // load together with enable in idle emits nothing
    clear_col();
    step(0, 1, 1, 32'h5, 3);
    chk("load+en left", {26'b0, left0}, 32'h3);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    chk("load+en msb", col0, 32'h5);
    chk("load+en lsb", col1, 32'h5);

    // load during shift ignored
    clear_col();
    step(0, 1, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    step(0, 1, 1, 32'hFFFF_FFFF, 0);
    n = 6;
    while (m_busy && n < 40) begin
      step(0, 0, 1, 0, 0);
      n++;
    end
    chk("midload cycles", n, 32);
    chk("midload msb", col0, 32'h0);
    chk("midload lsb", col1, 32'h0);

    // back-to-back: second load on the done cycle
    clear_col();
    step(0, 1, 0, 32'h6, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    step(0, 1, 1, 32'h1, 1);
    step(0, 0, 1, 0, 0);
    chk("b2b out", {31'b0, out0}, 32'h1);
    chk("b2b dones", ndone0, 2);
    chk("b2b bits", col0, 32'hD);

    // reset mid-transfer
    clear_col();
    step(0, 1, 0, 32'hA5A5_0F0F, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("rst mid ready", {31'b0, ready1}, 32'h1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    chk("rst mid out", {31'b0, out0}, 32'h0);
    chk("rst mid done cnt", ndone0, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
